// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the core's memory stage.
// Read hits are answered in the same cycle. Misses and stores use a req/ack backing memory.
module dcache_responder #(
    parameter int unsigned LINES = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      dCacheAddr,
    input  logic             dCacheReadEn,
    input  logic             dCacheWriteEn,
    input  logic [31:0]      dCacheWriteData,
    output logic [31:0]      dCacheReadData,
    output logic             dCacheStall,
    output logic             memReq,
    output logic             memWe,
    output logic [31:0]      memAddr,
    output logic [31:0]      memWData,
    input  logic [31:0]      memRData,
    input  logic             memAck,
    output logic [CNT_W-1:0] rdHitCnt,
    output logic [CNT_W-1:0] rdMissCnt
);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {StIdle, StRdMiss, StWrThru} state_e;

    state_e             state_q;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               line_hit;
    logic               unused_addr_bits;

    assign idx      = dCacheAddr[IDX_W+1:2];
    assign tag      = dCacheAddr[31:IDX_W+2];
    // The latched request address is the only source for the fill location.
    assign req_idx  = memAddr[IDX_W+1:2];
    assign req_tag  = memAddr[31:IDX_W+2];
    assign line_hit = valid_q[idx] && (tag_q[idx] == tag);
    assign unused_addr_bits = ^{dCacheAddr[1:0], memAddr[1:0]};

    always_comb begin
        dCacheStall    = 1'b0;
        dCacheReadData = '0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (dCacheWriteEn) begin
                        dCacheStall = 1'b1;
                    end else if (dCacheReadEn) begin
                        if (line_hit) begin
                            dCacheReadData = data_q[idx];
                        end else begin
                            dCacheStall = 1'b1;
                        end
                    end
                end
                StRdMiss: begin
                    dCacheStall = !memAck;
                    if (memAck) begin
                        dCacheReadData = memRData;
                    end
                end
                StWrThru: dCacheStall = !memAck;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            valid_q   <= '0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
            rdHitCnt  <= '0;
            rdMissCnt <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (dCacheWriteEn) begin
                        memAddr  <= {dCacheAddr[31:2], 2'b00};
                        memWData <= dCacheWriteData;
                        memReq   <= 1'b1;
                        memWe    <= 1'b1;
                        state_q  <= StWrThru;
                    end else if (dCacheReadEn) begin
                        if (line_hit) begin
                            if (rdHitCnt != {CNT_W{1'b1}}) begin
                                rdHitCnt <= rdHitCnt + CNT_W'(1);
                            end
                        end else begin
                            memAddr <= {dCacheAddr[31:2], 2'b00};
                            memReq  <= 1'b1;
                            memWe   <= 1'b0;
                            state_q <= StRdMiss;
                            if (rdMissCnt != {CNT_W{1'b1}}) begin
                                rdMissCnt <= rdMissCnt + CNT_W'(1);
                            end
                        end
                    end
                end
                StRdMiss: begin
                    if (memAck) begin
                        valid_q[req_idx] <= 1'b1;
                        memReq           <= 1'b0;
                        state_q          <= StIdle;
                    end
                end
                StWrThru: begin
                    if (memAck) begin
                        memReq  <= 1'b0;
                        memWe   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StIdle && dCacheWriteEn && line_hit) begin
                data_q[idx] <= dCacheWriteData;
            end else if (state_q == StRdMiss && memAck) begin
                tag_q[req_idx]  <= req_tag;
                data_q[req_idx] <= memRData;
            end
        end
    end
endmodule
